// File: rtl/tt_um_unclegravity_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_unclegravity_neuron_mac
// Description : Single neuron for the neuralnet tile. The host streams signed
//               int8 weight/activation pairs on ui_in. Each pair is
//               multiply-accumulated. The pair flagged "last" closes the dot
//               product. The sum is then arithmetically shifted right by
//               SHIFT, saturated to 8 bits and held on uo_out.
//
//               This is a Tiny Tapeout user module. ena is ignored.
//
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               ena      - always 1, unused
//               ui_in    - data byte (signed weight or activation)
//               uio_in   - [0] valid, [1] last (taken with the activation
//                          byte only), [2] clr (synchronous, highest
//                          priority), [7:3] unused
//               uo_out   - registered neuron result
//               uio_out  - [4] ready, [5] done, [6] phase (1 = expect
//                          activation), [7] ovf (sticky), [3:0] = 0
//               uio_oe   - constant 8'hF0: status nibble driven, control
//                          nibble input
//
// Parameters  : N_MAX - pairs accumulated per dot product; later pairs are
//                       dropped and set ovf
//               ACC_W - signed accumulator width, >= 16+$clog2(N_MAX)+1
//               SHIFT - arithmetic right shift applied before saturation
//
// Config      : NEURON_RELU_EN - when defined, the output stage is a ReLU
//                                that clamps to 0..255 unsigned. Otherwise
//                                it saturates signed to -128..127.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_unclegravity_neuron_mac #(
    parameter int N_MAX = 16,
    parameter int ACC_W = 21,
    parameter int SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // The count must be able to hold N_MAX itself. That value marks the
    // accumulator as full.
    localparam int CNT_W = $clog2(N_MAX + 1);

    localparam logic [CNT_W-1:0]        C_N_MAX   = CNT_W'(N_MAX);
`ifdef NEURON_RELU_EN
    localparam logic signed [ACC_W-1:0] C_U8_MAX  = ACC_W'(255);
`else
    localparam logic signed [ACC_W-1:0] C_S8_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] C_S8_MIN  = ACC_W'(-128);
`endif

    typedef enum logic [1:0] {
        S_W   = 2'd0,   // await weight
        S_X   = 2'd1,   // await activation
        S_ACC = 2'd2,   // multiply-accumulate
        S_OUT = 2'd3    // scale, saturate, emit
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                     w_valid;
    logic                     w_last_in;
    logic                     w_clr;
    logic                     w_ready;
    logic                     w_unused;

    logic signed [7:0]        r_w;
    logic signed [7:0]        r_x;
    logic                     r_last;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [7:0]               r_uo;
    logic                     r_done;
    logic                     r_ovf;

    logic signed [15:0]       w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [7:0]               w_sat;

    assign w_valid   = uio_in[0];
    assign w_last_in = uio_in[1];
    assign w_clr     = uio_in[2];
    assign w_unused  = &{1'b0, ena, uio_in[7:3]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_W;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and ready. Bytes arriving while ready is low are lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_W: begin
                w_ready = 1'b1;
                if (w_valid) w_next = S_X;
            end
            S_X: begin
                w_ready = 1'b1;
                if (w_valid) w_next = S_ACC;
            end
            S_ACC:   w_next = r_last ? S_OUT : S_W;
            S_OUT:   w_next = S_W;
            default: w_next = S_W;
        endcase
        if (w_clr) w_next = S_W;
    end

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    assign w_prod     = r_w * r_x;
    assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
    assign w_shifted  = r_acc >>> SHIFT;

`ifdef NEURON_RELU_EN
    always_comb begin
        w_sat = w_shifted[7:0];
        if (w_shifted < 0)             w_sat = 8'h00;
        else if (w_shifted > C_U8_MAX) w_sat = 8'hFF;
    end
`else
    always_comb begin
        w_sat = w_shifted[7:0];
        if (w_shifted > C_S8_MAX)      w_sat = 8'h7F;
        else if (w_shifted < C_S8_MIN) w_sat = 8'h80;
    end
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w    <= '0;
            r_x    <= '0;
            r_last <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_uo   <= '0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_clr) begin
            // clr wins over everything, including a byte presented this cycle
            r_acc  <= '0;
            r_cnt  <= '0;
            r_uo   <= '0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_W: begin
                    if (w_valid) begin
                        r_w    <= ui_in;
                        r_done <= 1'b0;
                    end
                end
                S_X: begin
                    if (w_valid) begin
                        r_x    <= ui_in;
                        r_last <= w_last_in;
                    end
                end
                S_ACC: begin
                    if (r_cnt < C_N_MAX) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // ovf stays set through result emission; only clr
                        // or reset clears it
                        r_ovf <= 1'b1;
                    end
                end
                S_OUT: begin
                    r_uo   <= w_sat;
                    r_done <= 1'b1;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign uo_out  = r_uo;
    assign uio_out = {r_ovf, (r_state == S_X), r_done, w_ready, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
`default_nettype wire
